// File: rtl/man_deframer.sv
// Manchester line deframer: half-bit pair sampler, preamble/SFD hunter,
// LSB-first byte assembler and a first-word fall-through FIFO of {last, data}.
module man_deframer #(
  parameter int         PRE_MIN    = 8,
  parameter logic [7:0] SFD        = 8'hD5,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       man_code,
  input  logic       man_sync,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       in_frame,
  output logic       code_err,
  output logic       frag_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_HUNT, S_SFD, S_DATA} state_t;

  state_t     r_state, w_state_n;

  logic       r_sync_d, r_phase, r_half_a;
  logic       r_pv, r_pbit, r_pbad;
  logic       w_samp, w_pair_bad;

  logic [7:0] r_pre_cnt, w_pre_n, w_pre_inc;
  logic       r_prev_bit, w_prev_n;
  logic [7:0] r_win, w_win_n;
  logic [6:0] r_cnt, w_cnt_n;
  logic [7:0] r_shift, w_shift_n;
  logic [7:0] r_hold, w_hold_n;
  logic       r_hold_vld, w_hold_vld_n;
  logic       r_viol, w_viol_n;
  logic       w_push;
  logic [8:0] w_push_word;
  logic       w_cerr, w_ferr;
  logic       r_cerr, r_ferr, r_ovf;

  logic [8:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_fcnt;
  logic          w_full, w_pop, w_wr, w_drop;

  // Stage 0: sample halves on the first cycle of each strobe
  assign w_samp     = man_sync & ~r_sync_d;
  assign w_pair_bad = (r_half_a == man_code);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_d <= 1'b0;
      r_phase  <= 1'b0;
      r_pv     <= 1'b0;
    end else begin
      r_sync_d <= man_sync;
      r_pv     <= 1'b0;
      if (w_samp) begin
        if (!r_phase) begin
          r_half_a <= man_code;
          r_phase  <= 1'b1;
        end else begin
          r_pv   <= 1'b1;
          r_pbit <= man_code;
          r_pbad <= w_pair_bad;
          // While hunting, a bad pair slides the pairing by one half
          if (w_pair_bad && r_state == S_HUNT) r_half_a <= man_code;
          else                                 r_phase  <= 1'b0;
        end
      end
    end
  end

  // Stage 1: framing state machine on decoded pairs
  assign w_pre_inc = (r_pre_cnt == 8'd0 || r_pbit != r_prev_bit) ? r_pre_cnt + 8'd1 : 8'd1;

  always_comb begin
    w_state_n    = r_state;
    w_pre_n      = r_pre_cnt;
    w_prev_n     = r_prev_bit;
    w_win_n      = r_win;
    w_cnt_n      = r_cnt;
    w_shift_n    = r_shift;
    w_hold_n     = r_hold;
    w_hold_vld_n = r_hold_vld;
    w_viol_n     = r_viol;
    w_push       = 1'b0;
    w_push_word  = 9'd0;
    w_cerr       = 1'b0;
    w_ferr       = 1'b0;
    if (r_pv) begin
      case (r_state)
        S_HUNT: begin
          if (r_pbad) begin
            w_pre_n = 8'd0;
          end else begin
            w_prev_n = r_pbit;
            w_pre_n  = w_pre_inc;
            if (w_pre_inc >= 8'(PRE_MIN)) begin
              w_state_n = S_SFD;
              w_pre_n   = 8'd0;
              w_win_n   = 8'd0;
              w_cnt_n   = 7'd0;
            end
          end
        end
        S_SFD: begin
          if (r_pbad) begin
            w_state_n = S_HUNT;
          end else begin
            w_win_n = {r_pbit, r_win[7:1]};
            w_cnt_n = r_cnt + 7'd1;
            if (r_cnt >= 7'd7 && {r_pbit, r_win[7:1]} == SFD) begin
              w_state_n    = S_DATA;
              w_cnt_n      = 7'd0;
              w_hold_vld_n = 1'b0;
              w_viol_n     = 1'b0;
            end else if (r_cnt == 7'd63) begin
              w_state_n = S_HUNT;
            end
          end
        end
        S_DATA: begin
          if (r_pbad) begin
            // A lone violation is only reported once the next pair proves valid
            if (r_viol) begin
              w_push       = r_hold_vld;
              w_push_word  = {1'b1, r_hold};
              w_ferr       = (r_cnt[2:0] != 3'd0);
              w_state_n    = S_HUNT;
              w_hold_vld_n = 1'b0;
              w_viol_n     = 1'b0;
            end else begin
              w_viol_n = 1'b1;
            end
          end else begin
            w_cerr    = r_viol;
            w_viol_n  = 1'b0;
            w_shift_n = {r_pbit, r_shift[7:1]};
            w_cnt_n   = r_cnt + 7'd1;
            if (r_cnt[2:0] == 3'd7) begin
              w_cnt_n      = 7'd0;
              w_push       = r_hold_vld;
              w_push_word  = {1'b0, r_hold};
              w_hold_n     = {r_pbit, r_shift[7:1]};
              w_hold_vld_n = 1'b1;
            end
          end
        end
        default: w_state_n = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_HUNT;
      r_pre_cnt  <= 8'd0;
      r_prev_bit <= 1'b0;
      r_win      <= 8'd0;
      r_cnt      <= 7'd0;
      r_hold_vld <= 1'b0;
      r_viol     <= 1'b0;
      r_cerr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_pre_cnt  <= w_pre_n;
      r_prev_bit <= w_prev_n;
      r_win      <= w_win_n;
      r_cnt      <= w_cnt_n;
      r_hold_vld <= w_hold_vld_n;
      r_viol     <= w_viol_n;
      r_cerr     <= w_cerr;
      r_ferr     <= w_ferr;
      r_ovf      <= w_drop;
    end
  end

  always_ff @(posedge clk) begin
    r_shift <= w_shift_n;
    r_hold  <= w_hold_n;
  end

  // Stage 2: output FIFO; a full FIFO still accepts a push when popped
  assign out_valid = (r_fcnt != '0);
  assign w_full    = (r_fcnt == (AW+1)'(FIFO_DEPTH));
  assign w_pop     = out_valid & out_ready;
  assign w_wr      = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_wr)  r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= w_push_word;
  end

  assign out_data = out_valid ? r_mem[r_rp][7:0] : 8'h00;
  assign out_last = out_valid ? r_mem[r_rp][8]   : 1'b0;
  assign in_frame = (r_state == S_DATA);
  assign code_err = r_cerr;
  assign frag_err = r_ferr;
  assign overflow = r_ovf;

endmodule
